// File: rtl/io_bus_bridge.sv
// Memory-mapped I/O window: LEDs, seven-segment digits, synced switches, debounced buttons, timer.
// Reads are combinational from registered state, writes commit on the edge; the bus never stalls.
module io_bus_bridge #(
    parameter int                   ADDRWIDTH    = 32,
    parameter int                   DATAWIDTH    = 32,
    parameter int                   N_LED        = 36,
    parameter int                   N_SW         = 36,
    parameter int                   N_BTN        = 20,
    parameter logic [ADDRWIDTH-1:0] IO_BASE      = 32'hF000_0000,
    parameter int                   DEBOUNCE_CYC = 16
) (
    input  logic                 iClk,
    input  logic                 iReset_n,
    input  logic [ADDRWIDTH-1:0] iAB,
    input  logic                 iWR,
    input  logic                 iRD,
    input  logic [DATAWIDTH-1:0] iWriteData,
    output logic [DATAWIDTH-1:0] oReadData,
    output logic                 oSel,
    input  logic [N_SW-1:0]      iSW,
    input  logic [N_BTN-1:0]     iBTN,
    output logic [N_LED-1:0]     oLED,
    output logic [7:0]           oSSLED0,
    output logic [7:0]           oSSLED1,
    output logic [7:0]           oSSLED2,
    output logic [7:0]           oSSLED3,
    output logic [7:0]           oSSLED4,
    output logic [7:0]           oSSLED5,
    output logic [7:0]           oSSLED6,
    output logic [7:0]           oSSLED7
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [9:0] OFS_LED_LO   = 10'h000;
    localparam logic [9:0] OFS_LED_HI   = 10'h001;
    localparam logic [9:0] OFS_SW_LO    = 10'h002;
    localparam logic [9:0] OFS_SW_HI    = 10'h003;
    localparam logic [9:0] OFS_BTN      = 10'h004;
    localparam logic [9:0] OFS_BTN_EDGE = 10'h005;
    localparam logic [9:0] OFS_SEG_HEX  = 10'h006;
    localparam logic [9:0] OFS_SEG_CTRL = 10'h007;
    localparam logic [9:0] OFS_SEG_RAW0 = 10'h008;
    localparam logic [9:0] OFS_SEG_RAW1 = 10'h009;
    localparam logic [9:0] OFS_TIMER    = 10'h00A;

    logic [9:0] offset;
    logic       wr_en;
    logic [1:0] unused_addr;

    logic [N_LED-1:0]            led_q, led_d;
    logic [N_SW-1:0]             sw_meta_q, sw_sync_q;
    logic [N_BTN-1:0]            btn_meta_q, btn_sync_q;
    logic [N_BTN-1:0]            btn_db_q, btn_db_d;
    logic [N_BTN-1:0]            btn_edge_q, btn_edge_d;
    logic [N_BTN-1:0]            edge_clr;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]                 seg_hex_q, seg_hex_d;
    logic [16:0]                 seg_ctrl_q, seg_ctrl_d;
    logic [63:0]                 seg_raw_q, seg_raw_d;
    logic [31:0]                 timer_q, timer_d;
    logic [7:0][7:0]             seg_out_q, seg_out_d;
    logic [63:0]                 led_pad, sw_pad;
    logic [31:0]                 rdata;

    assign oSel        = (iAB[ADDRWIDTH-1:12] == IO_BASE[ADDRWIDTH-1:12]);
    assign offset      = iAB[11:2];
    assign wr_en       = iWR & oSel;
    assign unused_addr = iAB[1:0];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Bus writes; the timer increments unless this cycle loads it.
    always_comb begin
        led_d      = led_q;
        seg_hex_d  = seg_hex_q;
        seg_ctrl_d = seg_ctrl_q;
        seg_raw_d  = seg_raw_q;
        timer_d    = timer_q + 32'd1;
        edge_clr   = '0;
        if (wr_en) begin
            case (offset)
                OFS_LED_LO:   led_d[31:0]       = iWriteData[31:0];
                OFS_LED_HI:   led_d[N_LED-1:32] = iWriteData[N_LED-33:0];
                OFS_BTN_EDGE: edge_clr          = iWriteData[N_BTN-1:0];
                OFS_SEG_HEX:  seg_hex_d         = iWriteData[31:0];
                OFS_SEG_CTRL: seg_ctrl_d        = iWriteData[16:0];
                OFS_SEG_RAW0: seg_raw_d[31:0]   = iWriteData[31:0];
                OFS_SEG_RAW1: seg_raw_d[63:32]  = iWriteData[31:0];
                OFS_TIMER:    timer_d           = iWriteData[31:0];
                default: ;
            endcase
        end
    end

    // A synced value differing from the debounced level counts up; any return to
    // the debounced level (i.e. any bounce) restarts the count from zero.
    always_comb begin
        btn_db_d = btn_db_q;
        cnt_d    = '0;
        for (int k = 0; k < N_BTN; k++) begin
            if (btn_sync_q[k] != btn_db_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    btn_db_d[k] = btn_sync_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
        btn_edge_d = (btn_edge_q & ~edge_clr) | (btn_db_d & ~btn_db_q);
    end

    // Digit drive is computed from next-state config so it lands with the write.
    always_comb begin
        seg_out_d = '0;
        for (int k = 0; k < 8; k++) begin
            if (seg_ctrl_d[16]) begin
                seg_out_d[k] = seg_raw_d[8*k +: 8];
            end else if (seg_ctrl_d[k]) begin
                seg_out_d[k] = {seg_ctrl_d[8+k], hex7(seg_hex_d[4*k +: 4])};
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_db_q   <= '0;
            btn_edge_q <= '0;
            cnt_q      <= '0;
            seg_hex_q  <= '0;
            seg_ctrl_q <= '0;
            seg_raw_q  <= '0;
            timer_q    <= '0;
            seg_out_q  <= '0;
        end else begin
            led_q      <= led_d;
            sw_meta_q  <= iSW;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= iBTN;
            btn_sync_q <= btn_meta_q;
            btn_db_q   <= btn_db_d;
            btn_edge_q <= btn_edge_d;
            cnt_q      <= cnt_d;
            seg_hex_q  <= seg_hex_d;
            seg_ctrl_q <= seg_ctrl_d;
            seg_raw_q  <= seg_raw_d;
            timer_q    <= timer_d;
            seg_out_q  <= seg_out_d;
        end
    end

    assign led_pad = 64'(led_q);
    assign sw_pad  = 64'(sw_sync_q);

    always_comb begin
        rdata = '0;
        if (iRD && oSel) begin
            case (offset)
                OFS_LED_LO:   rdata = led_pad[31:0];
                OFS_LED_HI:   rdata = led_pad[63:32];
                OFS_SW_LO:    rdata = sw_pad[31:0];
                OFS_SW_HI:    rdata = sw_pad[63:32];
                OFS_BTN:      rdata = 32'(btn_db_q);
                OFS_BTN_EDGE: rdata = 32'(btn_edge_q);
                OFS_SEG_HEX:  rdata = seg_hex_q;
                OFS_SEG_CTRL: rdata = 32'(seg_ctrl_q);
                OFS_SEG_RAW0: rdata = seg_raw_q[31:0];
                OFS_SEG_RAW1: rdata = seg_raw_q[63:32];
                OFS_TIMER:    rdata = timer_q;
                default: ;
            endcase
        end
    end

    assign oReadData = rdata;
    assign oLED      = led_q;
    assign oSSLED0   = seg_out_q[0];
    assign oSSLED1   = seg_out_q[1];
    assign oSSLED2   = seg_out_q[2];
    assign oSSLED3   = seg_out_q[3];
    assign oSSLED4   = seg_out_q[4];
    assign oSSLED5   = seg_out_q[5];
    assign oSSLED6   = seg_out_q[6];
    assign oSSLED7   = seg_out_q[7];

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge: a table of bus vectors plus hand sequences for
// segments, synchronisers, debounce/edge flags, timer wrap and asynchronous reset.
module tb_io_bus_bridge;

    localparam int          DEB = 16;
    localparam logic [31:0] B   = 32'hF000_0000;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic [31:0] iAB;
    logic        iWR, iRD;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oSel;
    logic [35:0] iSW;
    logic [19:0] iBTN;
    logic [35:0] oLED;
    logic [7:0]  oSSLED0, oSSLED1, oSSLED2, oSSLED3, oSSLED4, oSSLED5, oSSLED6, oSSLED7;
    logic [7:0]  seg_o [8];

    int checks = 0;
    int errors = 0;

    io_bus_bridge #(.DEBOUNCE_CYC(DEB)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iAB(iAB), .iWR(iWR), .iRD(iRD),
        .iWriteData(iWriteData), .oReadData(oReadData), .oSel(oSel),
        .iSW(iSW), .iBTN(iBTN), .oLED(oLED),
        .oSSLED0(oSSLED0), .oSSLED1(oSSLED1), .oSSLED2(oSSLED2), .oSSLED3(oSSLED3),
        .oSSLED4(oSSLED4), .oSSLED5(oSSLED5), .oSSLED6(oSSLED6), .oSSLED7(oSSLED7)
    );

    always #5 iClk = ~iClk;

    assign seg_o[0] = oSSLED0;
    assign seg_o[1] = oSSLED1;
    assign seg_o[2] = oSSLED2;
    assign seg_o[3] = oSSLED3;
    assign seg_o[4] = oSSLED4;
    assign seg_o[5] = oSSLED5;
    assign seg_o[6] = oSSLED6;
    assign seg_o[7] = oSSLED7;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_sel;
        logic [35:0] exp_led;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is just after a rising edge; returns one edge later.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        iAB = a; iWriteData = d; iWR = 1'b1;
        @(posedge iClk);
        #1;
        iWR = 1'b0; iAB = '0; iWriteData = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        iAB = a; iRD = 1'b1;
        #2;
        d = oReadData;
        iRD = 1'b0; iAB = '0;
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, 64'(d), 64'(exp));
    endtask

    initial begin
        logic [7:0] exp_seg [8];

        iReset_n = 1'b0; iAB = '0; iWR = 1'b0; iRD = 1'b0; iWriteData = '0;
        iSW = '0; iBTN = '0;

        // ---- reset state: every offset reads 0, outputs clear ----
        #3;
        for (int o = 0; o <= 'h2C; o += 4) check_read($sformatf("rst_rd_%02h", o), B + o, 32'h0);
        check("rst_led", 64'(oLED), 64'h0);
        for (int k = 0; k < 8; k++) check($sformatf("rst_seg%0d", k), 64'(seg_o[k]), 64'h0);
        @(negedge iClk);
        iReset_n = 1'b1;
        @(posedge iClk);
        #1;

        // ---- table-driven bus vectors; exp_led is the state before the vector's edge ----
        vecs[0]  = '{1'b1, 1'b0, B + 32'h000,  32'hA5A5_A5A5, 32'h0,         1'b1, 36'h0};
        vecs[1]  = '{1'b1, 1'b0, B + 32'h004,  32'h0000_000F, 32'h0,         1'b1, 36'h0_A5A5_A5A5};
        vecs[2]  = '{1'b0, 1'b1, B + 32'h000,  32'h0,         32'hA5A5_A5A5, 1'b1, 36'hF_A5A5_A5A5};
        vecs[3]  = '{1'b0, 1'b1, B + 32'h004,  32'h0,         32'h0000_000F, 1'b1, 36'hF_A5A5_A5A5};
        vecs[4]  = '{1'b1, 1'b0, B + 32'h1000, 32'h1234_5678, 32'h0,         1'b0, 36'hF_A5A5_A5A5};
        vecs[5]  = '{1'b0, 1'b1, B + 32'h1000, 32'h0,         32'h0,         1'b0, 36'hF_A5A5_A5A5};
        vecs[6]  = '{1'b0, 1'b1, B + 32'h000,  32'h0,         32'hA5A5_A5A5, 1'b1, 36'hF_A5A5_A5A5};
        vecs[7]  = '{1'b1, 1'b0, B + 32'h004,  32'hFFFF_FFF5, 32'h0,         1'b1, 36'hF_A5A5_A5A5};
        vecs[8]  = '{1'b0, 1'b1, B + 32'h004,  32'h0,         32'h0000_0005, 1'b1, 36'h5_A5A5_A5A5};
        vecs[9]  = '{1'b1, 1'b0, B + 32'h02C,  32'hFFFF_FFFF, 32'h0,         1'b1, 36'h5_A5A5_A5A5};
        vecs[10] = '{1'b0, 1'b1, B + 32'h02C,  32'h0,         32'h0,         1'b1, 36'h5_A5A5_A5A5};
        vecs[11] = '{1'b0, 1'b1, B + 32'h003,  32'h0,         32'hA5A5_A5A5, 1'b1, 36'h5_A5A5_A5A5};
        vecs[12] = '{1'b0, 1'b0, B + 32'h000,  32'h0,         32'h0,         1'b1, 36'h5_A5A5_A5A5};
        vecs[13] = '{1'b0, 1'b1, 32'hE000_0000, 32'h0,        32'h0,         1'b0, 36'h5_A5A5_A5A5};
        vecs[14] = '{1'b0, 1'b1, B + 32'hFFC,  32'h0,         32'h0,         1'b1, 36'h5_A5A5_A5A5};
        vecs[15] = '{1'b1, 1'b0, B + 32'h018,  32'h0123_4567, 32'h0,         1'b1, 36'h5_A5A5_A5A5};
        vecs[16] = '{1'b1, 1'b0, B + 32'h01C,  32'h0000_01FF, 32'h0,         1'b1, 36'h5_A5A5_A5A5};
        vecs[17] = '{1'b0, 1'b1, B + 32'h018,  32'h0,         32'h0123_4567, 1'b1, 36'h5_A5A5_A5A5};
        vecs[18] = '{1'b0, 1'b1, B + 32'h01C,  32'h0,         32'h0000_01FF, 1'b1, 36'h5_A5A5_A5A5};

        for (int i = 0; i < 19; i++) begin
            iWR = vecs[i].wr; iRD = vecs[i].rd; iAB = vecs[i].addr; iWriteData = vecs[i].wdata;
            #3;
            check($sformatf("vec%0d_sel", i), 64'(oSel), 64'(vecs[i].exp_sel));
            check($sformatf("vec%0d_rd", i), 64'(oReadData), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_led", i), 64'(oLED), 64'(vecs[i].exp_led));
            @(posedge iClk);
            #1;
            iWR = 1'b0; iRD = 1'b0; iAB = '0; iWriteData = '0;
        end

        // ---- hex mode: 0123_4567, all enabled, dp on digit 0 ----
        exp_seg = '{8'h87, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
        for (int k = 0; k < 8; k++) check($sformatf("hexA_seg%0d", k), 64'(seg_o[k]), 64'(exp_seg[k]));

        bus_write(B + 32'h01C, 32'h0000_80FF);
        check("dp_move_seg0", 64'(oSSLED0), 64'h07);
        check("dp_move_seg7", 64'(oSSLED7), 64'hBF);

        bus_write(B + 32'h018, 32'h89AB_CDEF);
        exp_seg = '{8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'hFF};
        for (int k = 0; k < 8; k++) check($sformatf("hexB_seg%0d", k), 64'(seg_o[k]), 64'(exp_seg[k]));

        bus_write(B + 32'h01C, 32'h0000_80FE);
        check("dis_seg0", 64'(oSSLED0), 64'h00);
        bus_write(B + 32'h020, 32'h4433_2211);
        bus_write(B + 32'h024, 32'h8877_6655);
        check("raw_off_seg1", 64'(oSSLED1), 64'h79);
        bus_write(B + 32'h01C, 32'h0001_0000);
        exp_seg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int k = 0; k < 8; k++) check($sformatf("raw_seg%0d", k), 64'(seg_o[k]), 64'(exp_seg[k]));

        // ---- switch synchroniser: two-cycle lag ----
        iSW = 36'hA_1234_5678;
        @(posedge iClk); #1;
        check_read("sw_lag1", B + 32'h008, 32'h0);
        @(posedge iClk); #1;
        check_read("sw_lo", B + 32'h008, 32'h1234_5678);
        check_read("sw_hi", B + 32'h00C, 32'h0000_000A);

        // ---- bounce BTN[3] every 5 cycles, then hold high ----
        for (int t = 0; t < 8; t++) begin
            iBTN[3] = ~iBTN[3];
            repeat (5) @(posedge iClk);
            #1;
        end
        check_read("bounce_btn", B + 32'h010, 32'h0);
        check_read("bounce_edge", B + 32'h014, 32'h0);
        iBTN[3] = 1'b1;
        for (int c = 1; c <= DEB + 2; c++) begin
            @(posedge iClk); #1;
            if (c == DEB + 1) check_read("db_early", B + 32'h010, 32'h0);
            if (c == DEB + 2) begin
                check_read("db_rise", B + 32'h010, 32'h8);
                check_read("db_edge", B + 32'h014, 32'h8);
            end
        end

        // ---- W1C: quiet clear, then clear colliding with a new rise ----
        bus_write(B + 32'h014, 32'h8);
        check_read("w1c_quiet1", B + 32'h014, 32'h0);
        iBTN[3] = 1'b0;
        repeat (DEB + 4) @(posedge iClk);
        #1;
        check_read("db_fall", B + 32'h010, 32'h0);
        check_read("fall_no_edge", B + 32'h014, 32'h0);
        iBTN[3] = 1'b1;
        repeat (DEB + 1) @(posedge iClk);
        #1;
        bus_write(B + 32'h014, 32'h8);
        check_read("w1c_collide", B + 32'h014, 32'h8);
        check_read("collide_btn", B + 32'h010, 32'h8);
        bus_write(B + 32'h014, 32'h8);
        check_read("w1c_quiet2", B + 32'h014, 32'h0);

        // ---- timer load and wrap ----
        bus_write(B + 32'h028, 32'hFFFF_FFFE);
        check_read("tmr_load", B + 32'h028, 32'hFFFF_FFFE);
        @(posedge iClk); #1;
        check_read("tmr_ffff", B + 32'h028, 32'hFFFF_FFFF);
        @(posedge iClk); #1;
        check_read("tmr_wrap", B + 32'h028, 32'h0000_0000);
        @(posedge iClk); #1;
        check_read("tmr_one", B + 32'h028, 32'h0000_0001);

        // ---- asynchronous reset mid-count, with buttons 3 and 5 held ----
        iBTN[5] = 1'b1;
        repeat (8) @(posedge iClk);
        #1;
        iReset_n = 1'b0;
        #1;
        check_read("rst_tmr", B + 32'h028, 32'h0);
        check("rst2_led", 64'(oLED), 64'h0);
        check("rst2_seg0", 64'(oSSLED0), 64'h0);
        @(posedge iClk); #1;
        check_read("rst_hold_tmr", B + 32'h028, 32'h0);
        iReset_n = 1'b1;
        check_read("post_rst_led", B + 32'h000, 32'h0);
        for (int c = 1; c <= DEB + 2; c++) begin
            @(posedge iClk); #1;
            if (c == DEB + 1) check_read("rst_db_early", B + 32'h010, 32'h0);
            if (c == DEB + 2) begin
                check_read("rst_db_rise", B + 32'h010, 32'h28);
                check_read("rst_db_edge", B + 32'h014, 32'h28);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
